id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the 32x32 register file.
- Captures the register file's combinational read data with the decoded fields, and registers everything into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles.
- Honours downstream hold and branch-mispredict flush.
- Keeps a saturating bubble counter for performance analysis.

Parameters:
- CTRL_W, 16, width of opaque decoded control bundle passed to EX.
- XLEN, 32, datapath width; must match register file data width.

Ports:
- clk  input  1  rising-edge clock shared with register file.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  decode slot holds a real instruction.
- id_pc  input  XLEN  PC of decoded instruction.
- id_rs1  input  5  source reg 1; also drives register file read_reg1.
- id_rs2  input  5  source reg 2; also drives register file read_reg2.
- id_use_rs1  input  1  instruction actually reads rs1.
- id_use_rs2  input  1  instruction actually reads rs2.
- id_rd  input  5  destination register.
- id_imm  input  XLEN  sign-extended immediate.
- id_ctrl  input  CTRL_W  decoded control bundle.
- id_mem_read  input  1  instruction is a load.
- id_reg_write  input  1  instruction writes rd.
- rf_data1  input  XLEN  register file read_data1.
- rf_data2  input  XLEN  register file read_data2.
- wb_reg_write  input  1  writeback write enable (same signal driving register file).
- wb_rd  input  5  writeback destination.
- wb_data  input  XLEN  writeback data.
- ex_hold  input  1  EX cannot accept; hold ID/EX contents.
- flush  input  1  mispredict; kill instruction entering ID/EX.
- stall_out  output  1  freeze PC and IF/ID this cycle.
- ex_valid  output  1  ID/EX holds a real instruction.
- ex_pc, ex_imm  output  XLEN  registered copies.
- ex_rs1_data, ex_rs2_data  output  XLEN  registered operand values.
- ex_rs1, ex_rs2, ex_rd  output  5  registered indices (for EX forwarding).
- ex_ctrl  output  CTRL_W  registered control.
- ex_mem_read, ex_reg_write  output  1  registered; forced 0 when ex_valid=0.
- bubble_count  output  32  saturating count of bubble cycles inserted.

Behaviour:
- Reset (rst=1 at posedge): all ex_* outputs 0, ex_valid=0, bubble_count=0. stall_out is combinational and evaluates with ex_valid=0, so it is 0 during reset.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_out = load_use | ex_hold (combinational, same cycle).
- Register update priority per posedge:
  - rst
  - flush: ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; other fields don't-care but must not be X.
  - ex_hold: all ID/EX fields keep their values.
  - load_use: bubble, with ex_valid/ex_mem_read/ex_reg_write<=0.
  - Otherwise capture id_* fields; ex_valid<=id_valid; ex_mem_read and ex_reg_write are gated by id_valid.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Operand values: operand = rf_data unless the write-through bypass applies (see Optional Feature). Index 0 always yields 0 regardless of rf_data (register x0 is never written but its array entry is uninitialised).
- bubble_count increments by 1 on each posedge where a load_use bubble is inserted and neither rst, flush nor ex_hold is active; it saturates at 0xFFFFFFFF. Flush and hold cycles are not counted.
- Simultaneous flush and load_use: flush wins, no count, stall_out still 1 that cycle (harmless; upstream is also flushing).
- Reset mid-stall: stall_out drops the cycle after reset because ex_valid=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: the register file writes at posedge and reads combinationally, so a same-cycle writeback is not visible to the read. When wb_reg_write & wb_rd!=0 & wb_rd==id_rsN, operand N is wb_data instead of rf_data.
- Undefined: operands are rf_data only, and the EX-stage forwarding unit must cover the WB-to-ID distance.

Test Plan:
- Reset with id_valid=1 → ex_valid=0, bubble_count=0, stall_out=0 on cycle after rst deasserts.
- Load x5 in ID/EX (ex_mem_read=1, ex_rd=5); ID issues add reading rs1=5, use_rs1=1 → stall_out=1; next cycle ex_valid=0; following cycle add captured; bubble_count=1.
- Same load with ID rs2=5 but use_rs2=0 → stall_out=0, no bubble, count unchanged.
- ex_hold=1 for 3 cycles while id_pc changes → ex_pc stays 0x100 and stall_out=1 throughout; release → next id_pc captured.
- flush=1 with id_valid=1, id_pc=0x200 → ex_valid=0, ex_reg_write=0 next cycle.
- WB_BYPASS_EN defined: wb_rd=7, wb_data=0xDEADBEEF, rf_data1=0x11, id_rs1=7 → ex_rs1_data=0xDEADBEEF. Undefined → 0x11. With id_rs1=0 → 0 in both builds.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbling, hold/flush and a saturating bubble counter (WB_BYPASS_EN adds writeback write-through to operands)
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [31:0]       bubble_count
);
    logic              valid_q, valid_d, mem_read_q, mem_read_d, reg_write_q, reg_write_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, d1_q, d1_d, d2_q, d2_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              load_use, capture;
    logic [XLEN-1:0]   op1, op2;

    assign load_use = valid_q && mem_read_q && rd_q != 5'd0 && id_valid &&
                      ((id_use_rs1 && id_rs1 == rd_q) || (id_use_rs2 && id_rs2 == rd_q));
    assign stall_out = load_use || ex_hold;
    assign capture = !flush && !ex_hold && !load_use;

`ifdef WB_BYPASS_EN
    // the register file cannot show a same-cycle write, so forward it here
    assign op1 = id_rs1 == 5'd0 ? '0 : (wb_reg_write && wb_rd == id_rs1) ? wb_data : rf_data1;
    assign op2 = id_rs2 == 5'd0 ? '0 : (wb_reg_write && wb_rd == id_rs2) ? wb_data : rf_data2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
    assign op1 = id_rs1 == 5'd0 ? '0 : rf_data1;
    assign op2 = id_rs2 == 5'd0 ? '0 : rf_data2;
`endif

    // next state: flush beats hold beats load-use bubble beats capture
    always_comb begin
        valid_d     = flush ? 1'b0 : ex_hold ? valid_q     : load_use ? 1'b0 : id_valid;
        mem_read_d  = flush ? 1'b0 : ex_hold ? mem_read_q  : load_use ? 1'b0 : id_valid && id_mem_read;
        reg_write_d = flush ? 1'b0 : ex_hold ? reg_write_q : load_use ? 1'b0 : id_valid && id_reg_write;
        pc_d        = capture ? id_pc   : pc_q;
        imm_d       = capture ? id_imm  : imm_q;
        d1_d        = capture ? op1     : d1_q;
        d2_d        = capture ? op2     : d2_q;
        rs1_d       = capture ? id_rs1  : rs1_q;
        rs2_d       = capture ? id_rs2  : rs2_q;
        rd_d        = capture ? id_rd   : rd_q;
        ctrl_d      = capture ? id_ctrl : ctrl_q;
        cnt_d       = (load_use && !flush && !ex_hold && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end

    // ID/EX pipeline register and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_reg_write = reg_write_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_rs1_data  = d1_q;
    assign ex_rs2_data  = d2_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized bench for id_ex_stage against a behavioural model, plus directed literal checks
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int CTRL_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, id_valid, id_use_rs1, id_use_rs2, id_mem_read, id_reg_write;
    logic [XLEN-1:0]   id_pc, id_imm, rf_data1, rf_data2, wb_data;
    logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write, ex_hold, flush;
    logic              stall_out, ex_valid, ex_mem_read, ex_reg_write;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       bubble_count;

    id_ex_stage #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .bubble_count(bubble_count)
    );

    // model of what the ID/EX register must hold
    bit              m_valid, m_mr, m_rw;
    logic [XLEN-1:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    longint          m_cnt;
    bit              started = 0;
    int              total = 0, passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 0) return '0;
`ifdef WB_BYPASS_EN
        if (wb_reg_write && wb_rd == rs) return wb_data;
`endif
        return rf;
    endfunction

    function automatic bit model_load_use();
        bool_dummy: begin end
        return m_valid && m_mr && m_rd != 0 && id_valid &&
               ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    endfunction

    // one clock: check stall before the edge, advance model, check registers after it
    task automatic step();
        bit lu;
        logic [XLEN-1:0] o1, o2;
        #1;
        lu = model_load_use();
        o1 = operand(id_rs1, rf_data1);
        o2 = operand(id_rs2, rf_data2);
        if (started) chk("stall_out", {63'd0, stall_out}, {63'd0, lu | ex_hold});
        @(posedge clk);
        if (rst) begin
            started = 1;
            {m_valid, m_mr, m_rw} = '0;
            m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
        end else if (flush) begin
            {m_valid, m_mr, m_rw} = '0;
        end else if (ex_hold) begin
        end else if (lu) begin
            {m_valid, m_mr, m_rw} = '0;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else begin
            m_valid = id_valid; m_mr = id_valid & id_mem_read; m_rw = id_valid & id_reg_write;
            m_pc = id_pc; m_imm = id_imm; m_d1 = o1; m_d2 = o2;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_ctrl = id_ctrl;
        end
        #1;
        if (started) begin
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
            chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_mr});
            chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_rw});
            chk("bubble_count", {32'd0, bubble_count}, m_cnt);
            if (m_valid) begin
                chk("ex_pc", {32'd0, ex_pc}, {32'd0, m_pc});
                chk("ex_imm", {32'd0, ex_imm}, {32'd0, m_imm});
                chk("ex_rs1_data", {32'd0, ex_rs1_data}, {32'd0, m_d1});
                chk("ex_rs2_data", {32'd0, ex_rs2_data}, {32'd0, m_d2});
                chk("ex_idx", {49'd0, ex_rs1, ex_rs2, ex_rd}, {49'd0, m_rs1, m_rs2, m_rd});
                chk("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, m_ctrl});
            end
        end
        @(negedge clk);
    endtask

    task automatic id(input bit v, input logic [31:0] pc, input logic [4:0] r1, input bit u1,
                      input logic [4:0] r2, input bit u2, input logic [4:0] rd, input bit mr, input bit rw);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_mem_read = mr; id_reg_write = rw;
        id_imm = $urandom; id_ctrl = 16'($urandom); rf_data1 = $urandom; rf_data2 = $urandom;
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(3))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd7;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        logic [XLEN-1:0] exp_byp;
        rst = 1; ex_hold = 0; flush = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        id(1, 32'h50, 1, 1, 2, 1, 3, 0, 1);
        @(negedge clk);
        step(); step();
        rst = 0; id_valid = 0;
        #1 chk("stall_after_rst", {63'd0, stall_out}, 64'd0);
        step();
        chk("valid_after_rst", {63'd0, ex_valid}, 64'd0);
        chk("count_after_rst", {32'd0, bubble_count}, 64'd0);

        id(1, 32'hF0, 1, 0, 2, 0, 5, 1, 1); step();
        chk("load_in_ex", {58'd0, ex_mem_read, ex_rd}, {58'd0, 1'b1, 5'd5});
        id(1, 32'h104, 5, 1, 2, 0, 6, 0, 1);
        #1 chk("stall_load_use", {63'd0, stall_out}, 64'd1);
        step();
        chk("bubble_valid", {63'd0, ex_valid}, 64'd0);
        chk("bubble_count_1", {32'd0, bubble_count}, 64'd1);
        #1 chk("stall_released", {63'd0, stall_out}, 64'd0);
        step();
        chk("add_captured", {31'd0, ex_valid, ex_pc}, {31'd0, 1'b1, 32'h104});

        id(1, 32'h108, 1, 0, 2, 0, 5, 1, 1); step();
        id(1, 32'h10C, 1, 1, 5, 0, 6, 0, 1);
        #1 chk("no_stall_unused_rs2", {63'd0, stall_out}, 64'd0);
        step();
        chk("unused_rs2_pc", {32'd0, ex_pc}, 64'h10C);
        chk("unused_rs2_count", {32'd0, bubble_count}, 64'd1);

        id(1, 32'h100, 1, 1, 2, 1, 3, 0, 1); step();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc = 32'h200 + 32'(i * 4);
            #1 chk("stall_hold", {63'd0, stall_out}, 64'd1);
            step();
            chk("held_pc", {32'd0, ex_pc}, 64'h100);
        end
        ex_hold = 0; id_pc = 32'h300; step();
        chk("release_pc", {32'd0, ex_pc}, 64'h300);

        flush = 1; id(1, 32'h200, 1, 1, 2, 1, 9, 0, 1); step();
        chk("flush_kill", {62'd0, ex_valid, ex_reg_write}, 64'd0);
        flush = 0;

        wb_reg_write = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        id(1, 32'h400, 7, 1, 0, 0, 8, 0, 1); rf_data1 = 32'h11; step();
`ifdef WB_BYPASS_EN
        exp_byp = 32'hDEADBEEF;
`else
        exp_byp = 32'h11;
`endif
        chk("bypass_rs1", {32'd0, ex_rs1_data}, {32'd0, exp_byp});
        id(1, 32'h404, 0, 1, 0, 0, 8, 0, 1); rf_data1 = 32'h55; step();
        chk("x0_rs1", {32'd0, ex_rs1_data}, 64'd0);
        wb_reg_write = 0;

        for (int n = 0; n < 3000; n++) begin
            id($urandom_range(9) < 8, $urandom, pick(), $urandom_range(9) < 7, pick(),
               $urandom_range(9) < 7, pick(), $urandom_range(9) < 4, $urandom_range(1) == 1);
            wb_reg_write = $urandom_range(1) == 1; wb_rd = pick(); wb_data = $urandom;
            ex_hold = $urandom_range(9) == 0;
            flush = $urandom_range(19) == 0;
            rst = $urandom_range(199) == 0;
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
